// File: rtl/pe_systolic_dbw.sv
// pe_systolic_dbw: systolic PE with double-buffered weights, WS/OS modes and optional saturation
module pe_systolic_dbw #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 24,
  parameter int SIGNED = 1,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [DATA_W-1:0] act_in,
  input  logic              act_vld_in,
  output logic [DATA_W-1:0] act_out,
  output logic              act_vld_out,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_vld_in,
  output logic [DATA_W-1:0] w_out,
  output logic              w_vld_out,
  input  logic              w_swap,
  input  logic              w_zero,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic              psum_vld_in,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_vld_out,
  input  logic              acc_clr,
  input  logic              drain
);
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] shadow_q, shadow_d, active_q, active_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_base;
  logic [DATA_W-1:0] act_out_q, act_out_d, w_out_q, w_out_d;
  logic              act_vld_q, act_vld_d, w_vld_q, w_vld_d, psum_vld_q, psum_vld_d;
  logic [ACC_W-1:0]  psum_q, psum_d;
  logic              chg, mac_v;

  function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0] add, input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ps;
    logic [2*DATA_W-1:0] p;
    logic [ACC_W:0] s;
    logic [ACC_W-1:0] hi, lo;
    ps = $signed(a) * $signed(b);
    p = (SIGNED != 0) ? ps : a * b;
    s = (SIGNED != 0) ? {add[ACC_W-1], add} + {{(ACC_W+1-2*DATA_W){p[2*DATA_W-1]}}, p}
                      : {1'b0, add} + {{(ACC_W+1-2*DATA_W){1'b0}}, p};
    hi = (SIGNED != 0) ? {1'b0, {(ACC_W-1){1'b1}}} : '1;
    lo = (SIGNED != 0) ? {1'b1, {(ACC_W-1){1'b0}}} : '0;
    return (SATURATE == 0) ? s[ACC_W-1:0]
         : (SIGNED != 0) ? ((s[ACC_W] ^ s[ACC_W-1]) ? (s[ACC_W] ? lo : hi) : s[ACC_W-1:0])
         : (s[ACC_W] ? hi : s[ACC_W-1:0]);
  endfunction

  // next state: a mode change clears acc and suppresses psum/w valids for one cycle
  always_comb begin
    chg = mode != mode_q;
    mac_v = act_vld_in & w_vld_in;
    acc_base = (acc_clr | drain) ? '0 : acc_q;
    mode_d = mode;
    act_out_d = act_vld_in ? act_in : '0;
    act_vld_d = act_vld_in;
    shadow_d = mode_q ? shadow_q : w_zero ? '0 : w_vld_in ? w_in : shadow_q;
    active_d = mode_q ? active_q : w_zero ? '0 : w_swap ? shadow_q : active_q;
    w_out_d = (mode_q | w_vld_in) ? w_in : w_out_q;
    w_vld_d = w_vld_in & ~chg;
    psum_d = chg ? '0
           : mode_q ? (drain ? acc_q : psum_vld_in ? psum_in : '0)
           : act_vld_in ? mac(psum_vld_in ? psum_in : '0, act_in, active_q) : '0;
    psum_vld_d = ~chg & (mode_q ? (drain | psum_vld_in) : act_vld_in);
    acc_d = chg ? '0 : ~mode_q ? acc_q : mac_v ? mac(acc_base, act_in, w_in) : acc_base;
  end

  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      acc_q <= '0;
      act_out_q <= '0;
      act_vld_q <= 1'b0;
      w_out_q <= '0;
      w_vld_q <= 1'b0;
      psum_q <= '0;
      psum_vld_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      acc_q <= acc_d;
      act_out_q <= act_out_d;
      act_vld_q <= act_vld_d;
      w_out_q <= w_out_d;
      w_vld_q <= w_vld_d;
      psum_q <= psum_d;
      psum_vld_q <= psum_vld_d;
    end
  end

  assign act_out = act_out_q;
  assign act_vld_out = act_vld_q;
  assign w_out = w_out_q;
  assign w_vld_out = w_vld_q;
  assign psum_out = psum_q;
  assign psum_vld_out = psum_vld_q;
endmodule

// File: tb/tb_pe_systolic_dbw.sv
// tb_pe_systolic_dbw: scoreboard bench driving four parameterisations of pe_systolic_dbw in lockstep
module tb_pe_systolic_dbw;
  localparam int N = 4;
  localparam int AW [N] = '{24, 16, 16, 16};
  localparam int SG [N] = '{1, 1, 1, 0};
  localparam int ST [N] = '{0, 1, 0, 1};
  typedef struct packed {
    logic av; logic [7:0] ao; logic wv; logic [7:0] wo; logic pv; logic [23:0] po;
  } out_t;
  typedef out_t [N-1:0] all_t;

  logic clk = 0, rst = 0, mode = 0;
  logic act_vld = 0, w_vld = 0, psum_vld = 0, w_swap = 0, w_zero = 0, acc_clr = 0, drain = 0;
  logic [7:0] act = 0, w_in = 0;
  logic [23:0] psum_in = 0;
  out_t got [N];
  all_t exq [$];
  int n_chk = 0, n_pass = 0;
  bit m_mode [N];
  logic [7:0] m_sh [N], m_ac [N], m_wo [N];
  longint m_acc [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [AW[g]-1:0] po;
    logic av, wv, pv;
    logic [7:0] ao, wo;
    pe_systolic_dbw #(.DATA_W(8), .ACC_W(AW[g]), .SIGNED(SG[g]), .SATURATE(ST[g])) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .act_in(act), .act_vld_in(act_vld), .act_out(ao), .act_vld_out(av),
      .w_in(w_in), .w_vld_in(w_vld), .w_out(wo), .w_vld_out(wv),
      .w_swap(w_swap), .w_zero(w_zero),
      .psum_in(psum_in[AW[g]-1:0]), .psum_vld_in(psum_vld), .psum_out(po), .psum_vld_out(pv),
      .acc_clr(acc_clr), .drain(drain));
    assign got[g] = {av, ao, wv, wo, pv, 24'(po)};
  end

  task automatic check(string nm, logic [63:0] a, logic [63:0] x);
    n_chk++;
    if (a === x) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, a, x);
  endtask

  function automatic longint sv(longint raw, int w, int s);
    return (s != 0 && raw[w-1]) ? raw - (longint'(1) << w) : raw;
  endfunction

  // true sum from integer arithmetic, then clamped or wrapped into the accumulator range
  function automatic longint mac_m(int k, longint add, logic [7:0] a, logic [7:0] b);
    longint s, hi, lo;
    s = sv(add, AW[k], SG[k]) + sv(longint'(a), 8, SG[k]) * sv(longint'(b), 8, SG[k]);
    hi = (SG[k] != 0) ? (longint'(1) << (AW[k] - 1)) - 1 : (longint'(1) << AW[k]) - 1;
    lo = (SG[k] != 0) ? -(longint'(1) << (AW[k] - 1)) : 0;
    if (ST[k] != 0) s = (s > hi) ? hi : (s < lo) ? lo : s;
    return s & ((longint'(1) << AW[k]) - 1);
  endfunction

  task automatic model_rst();
    for (int k = 0; k < N; k++) begin
      m_mode[k] = 0; m_sh[k] = 0; m_ac[k] = 0; m_wo[k] = 0; m_acc[k] = 0;
    end
    exq.delete();
  endtask

  // predict next-cycle outputs for current inputs, queue them, then advance one clock
  task automatic step();
    all_t e;
    for (int k = 0; k < N; k++) begin
      longint msk, pin;
      bit chg;
      msk = (longint'(1) << AW[k]) - 1;
      pin = psum_vld ? (longint'(psum_in) & msk) : 0;
      chg = mode != m_mode[k];
      e[k].av = act_vld;
      e[k].ao = act_vld ? act : 8'd0;
      e[k].wv = w_vld & ~chg;
      if (!m_mode[k]) begin
        e[k].wo = w_vld ? w_in : m_wo[k];
        e[k].pv = act_vld;
        e[k].po = act_vld ? 24'(mac_m(k, pin, act, m_ac[k])) : 24'd0;
        if (w_zero) begin
          m_ac[k] = 0; m_sh[k] = 0;
        end else begin
          if (w_swap) m_ac[k] = m_sh[k];
          if (w_vld) m_sh[k] = w_in;
        end
      end else begin
        e[k].wo = w_in;
        e[k].pv = drain | psum_vld;
        e[k].po = drain ? 24'(m_acc[k]) : 24'(pin);
        if (acc_clr || drain) m_acc[k] = 0;
        if (act_vld && w_vld) m_acc[k] = mac_m(k, m_acc[k], act, w_in);
      end
      if (chg) begin
        m_acc[k] = 0; e[k].pv = 0; e[k].po = 0;
      end
      m_wo[k] = e[k].wo;
      m_mode[k] = mode;
    end
    exq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    act_vld = 0; w_vld = 0; psum_vld = 0; w_swap = 0; w_zero = 0; acc_clr = 0; drain = 0;
    act = 0; w_in = 0; psum_in = 0;
  endtask

  task automatic dchk(int k, longint v);
    check($sformatf("psum%0d", k), 64'({got[k].pv, got[k].po}), 64'({1'b1, 24'(v)}));
  endtask

  // monitor: compare every clocked output set against the queued prediction
  always @(posedge clk) begin
    all_t e;
    #1;
    if (exq.size() != 0) begin
      e = exq.pop_front();
      for (int k = 0; k < N; k++) check($sformatf("out%0d", k), 64'(got[k]), 64'(e[k]));
    end
  end

  initial begin
    model_rst();
    #1 rst = 1;
    #11;
    for (int k = 0; k < N; k++) check("reset", 64'(got[k]), 64'(0));
    rst = 0;
    clr_in();
    w_in = 8'hFD; w_vld = 1; step(); clr_in();
    w_swap = 1; step(); clr_in();
    act = 5; act_vld = 1; psum_in = 100; psum_vld = 1; step();
    dchk(0, 85);
    check("ws_act", 64'(got[0].ao), 64'(5));
    check("ws_w", 64'(got[0].wo), 64'(8'hFD));
    clr_in(); w_in = 2; w_vld = 1; step(); clr_in();
    w_swap = 1; step();
    for (int i = 1; i <= 3; i++) begin
      clr_in(); act = 8'(i); act_vld = 1; psum_vld = 1; w_in = 7; w_vld = (i == 1); step();
      dchk(0, 2 * i);
    end
    clr_in(); act = 4; act_vld = 1; psum_vld = 1; w_swap = 1; step(); dchk(0, 8);
    w_swap = 0; act = 1; step(); dchk(0, 7);
    clr_in(); w_swap = 1; w_vld = 1; w_in = 9; step();
    clr_in(); act = 1; act_vld = 1; step(); dchk(0, 7);
    clr_in(); w_swap = 1; step();
    clr_in(); act = 1; act_vld = 1; step(); dchk(0, 9);
    clr_in(); w_in = 127; w_vld = 1; step(); clr_in();
    w_swap = 1; step(); clr_in();
    act = 127; act_vld = 1; psum_in = 32000; psum_vld = 1; step();
    dchk(1, 32767); dchk(2, 48129); dchk(0, 48129);
    clr_in(); w_in = 255; w_vld = 1; step(); clr_in();
    w_swap = 1; step(); clr_in();
    act = 255; act_vld = 1; psum_vld = 1; step();
    dchk(3, 65025); dchk(0, 1);
    clr_in(); w_in = 9; w_vld = 1; step(); clr_in();
    w_swap = 1; step(); clr_in();
    w_zero = 1; step(); clr_in();
    act = 3; act_vld = 1; psum_in = 5; psum_vld = 1; step();
    dchk(3, 5); dchk(0, 5);
    clr_in(); mode = 1; step();
    acc_clr = 1; step();
    for (int i = 0; i < 3; i++) begin
      clr_in(); act = 8'(2 * i + 1); w_in = 8'(2 * i + 2); act_vld = 1; w_vld = 1; step();
    end
    clr_in(); drain = 1; step();
    for (int k = 0; k < N; k++) dchk(k, 44);
    step(); dchk(0, 0);
    clr_in(); psum_in = 11; psum_vld = 1; step(); dchk(0, 11); dchk(3, 11);
    clr_in(); acc_clr = 1; step();
    for (int i = 0; i < 3; i++) begin
      clr_in(); act = 8'(2 * i + 1); w_in = 8'(2 * i + 2); act_vld = 1; w_vld = 1; step();
    end
    clr_in();
    #3 rst = 1;
    #1;
    for (int k = 0; k < N; k++) check("rst_async", 64'(got[k]), 64'(0));
    model_rst();
    #10 rst = 0;
    step();
    drain = 1; step(); dchk(0, 0); dchk(1, 0);
    for (int i = 0; i < 1500; i++) begin
      clr_in();
      if ($urandom_range(0, 39) == 0) begin
        mode = ~mode;
        step();
        continue;
      end
      act = 8'($urandom); w_in = 8'($urandom); psum_in = 24'($urandom);
      act_vld = $urandom_range(0, 3) != 0;
      w_vld = $urandom_range(0, 1) != 0;
      psum_vld = $urandom_range(0, 2) != 0;
      w_swap = $urandom_range(0, 5) == 0;
      w_zero = $urandom_range(0, 24) == 0;
      acc_clr = $urandom_range(0, 15) == 0;
      drain = $urandom_range(0, 9) == 0;
      step();
    end
    clr_in(); step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pe_systolic_dbw.md
Name: pe_systolic_dbw

Overview:
- Parametrised systolic-array processing element; next generation of the single-mode 8-bit weight-stationary PE.
- Adds configurable data/accumulator widths and signed/unsigned arithmetic.
- Adds a double-buffered weight so the next tile's weights load while the current tile computes.
- Adds per-operand valid propagation, optional saturation, and an output-stationary (OS) mode with a drain chain.
- Instantiated as a rows x cols grid inside the TPU array.
  - Activations flow left to right.
  - Weights and partial sums flow top to bottom.

Parameters:
- DATA_W, 8: activation and weight width.
- ACC_W, 24: partial-sum and accumulator width. Must satisfy ACC_W >= 2*DATA_W.
- SIGNED, 1: 1 = two's-complement operands; 0 = unsigned.
- SATURATE, 0: 1 = clamp sums to the ACC_W range; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS).
- act_in  in  DATA_W  activation from the left neighbour.
- act_vld_in  in  1  act_in valid.
- act_out  out  DATA_W  activation to the right neighbour.
- act_vld_out  out  1  act_out valid.
- w_in  in  DATA_W  weight from above (load chain in WS, operand stream in OS).
- w_vld_in  in  1  w_in valid.
- w_out  out  DATA_W  weight to the PE below.
- w_vld_out  out  1  w_out valid.
- w_swap  in  1  WS: copy shadow weight into active weight.
- w_zero  in  1  WS: clear active and shadow weights.
- psum_in  in  ACC_W  partial sum from above / drain chain in.
- psum_vld_in  in  1  psum_in valid.
- psum_out  out  ACC_W  partial sum to below / drain chain out.
- psum_vld_out  out  1  psum_out valid.
- acc_clr  in  1  OS: clear accumulator.
- drain  in  1  OS: emit accumulator onto psum_out.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - All outputs go to 0, including all valid flags.
  - Internal state clears: shadow weight, active weight, acc, mode_q.
  - First valid output after reset release is no earlier than 1 cycle after the first valid input.
- Latency: every output is registered; 1 cycle from inputs to outputs.
- Activation path, both modes:
  - act_vld_out <= act_vld_in.
  - act_out <= act_in when act_vld_in, else 0.
- Arithmetic:
  - prod = act_in*operand, full 2*DATA_W width, sign- or zero-extended per SIGNED.
  - sum = addend + prod, computed ACC_W+1 wide.
  - SATURATE=1: clamp to [min,max] of ACC_W (signed range if SIGNED, else [0, 2^ACC_W-1]).
  - SATURATE=0: truncate to ACC_W.
- WS mode (mode_q=0):
  - Weight chain:
    - On w_vld_in: shadow <= w_in, w_out <= w_in, w_vld_out <= 1.
    - Otherwise: w_vld_out <= 0 and w_out holds.
  - Swap:
    - On w_swap: active <= shadow (value before any same-cycle load).
    - w_swap and w_vld_in in the same cycle: active gets the old shadow, shadow gets w_in.
  - w_zero has top priority over load and swap: active <= 0 and shadow <= 0.
  - Compute:
    - psum_vld_out <= act_vld_in.
    - If act_vld_in: psum_out <= sat(psum_in + act_in*active). A psum_in with psum_vld_in=0 is treated as 0.
    - Else psum_out <= 0.
  - The active weight used is the value before any same-cycle swap.
- OS mode (mode_q=1):
  - Weight stream: w_out <= w_in and w_vld_out <= w_vld_in every cycle. Shadow and active weights are ignored.
  - Accumulate: if act_vld_in && w_vld_in, acc <= sat(acc + act_in*w_in).
  - acc_clr: acc <= 0. If it coincides with a valid MAC, acc <= that single product (clear-then-accumulate).
  - Drain chain:
    - If drain: psum_out <= acc (the pre-update value), psum_vld_out <= 1, and acc <= 0, or the same-cycle product if a MAC coincides.
    - Else: psum_out <= psum_in when psum_vld_in, else 0; psum_vld_out <= psum_vld_in.
  - drain while psum_vld_in=1 is a controller error: the local acc wins and psum_in is dropped.
- Mode change:
  - mode is registered into mode_q.
  - The cycle mode_q changes, acc clears, and the psum/w output valids are forced to 0 for that cycle.
  - Shadow and active weights are preserved across the change.
  - The controller changes mode only while all input valids are 0.

Test Plan:
- WS basic, signed, DATA_W=8, ACC_W=24:
  - Load w=-3 (w_vld_in), then w_swap, then act=5 with psum_in=100.
  - Next cycle: psum_out=85, psum_vld_out=1, act_out=5, w_out=-3.
- Double buffer:
  - Active=2, shadow loaded with 7 while streaming act=1,2,3 (psum_in=0): outputs 2,4,6.
  - Then w_swap with act=4 in the same cycle: output 8; the following act=1 gives 7.
  - w_swap with simultaneous w_vld_in(9): active=7, shadow=9.
- Saturation, SATURATE=1, ACC_W=16, signed:
  - psum_in=32000, act=127, w=127: psum_out=32767.
  - With SATURATE=0 the same stimulus gives wrapped -17407.
- OS accumulate/drain:
  - acc_clr, then pairs (1,2),(3,4),(5,6), then drain: psum_out=44, psum_vld_out=1, acc=0 next cycle.
  - A drain chain value 11 on psum_in passes through unchanged with 1-cycle latency.
- Unsigned/edge, SIGNED=0:
  - act=255, w=255, psum_in=0: psum_out=65025.
  - w_zero while active=9: the following MAC adds 0.
- Reset mid-operation:
  - Assert rst asynchronously between clock edges during an OS accumulation (acc=44).
  - All outputs are 0 immediately.
  - After release, drain without a new MAC gives psum_out=0.
